// File: rtl/ctrl_pipe.sv
// Control pipeline: decodes the instruction in ID and moves its control bundle
// through EX, MEM and WB. CTRL_PIPE_PERF_CNT_EN adds retired/illegal counters.
module ctrl_pipe #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op_d,
  input  logic [2:0]           funct3_d,
  input  logic                 funct7b5_d,
  input  logic                 valid_d,
  input  logic                 flush_e,
  output logic [2:0]           imm_src_d,
  output logic                 reg_write_e,
  output logic                 mem_write_e,
  output logic                 branch_e,
  output logic                 jump_e,
  output logic                 alu_src_e,
  output logic                 alu_src_a_e,
  output logic [1:0]           result_src_e,
  output logic [ALUCTRL_W-1:0] alu_ctrl_e,
  output logic                 illegal_e,
  output logic                 reg_write_m,
  output logic                 mem_write_m,
  output logic [1:0]           result_src_m,
  output logic                 reg_write_w,
  output logic [1:0]           result_src_w,
  output logic                 valid_w
`ifdef CTRL_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [CNT_W-1:0]     illegal_cnt
`endif
);

  if (ALUCTRL_W < 4 || CNT_W < 1) begin : g_bad_param
    $error("ctrl_pipe: ALUCTRL_W must be >= 4 and CNT_W >= 1");
  end

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  logic       dec_legal, dec_rw, dec_mw, dec_br, dec_jp, dec_as, dec_asa;
  logic       dec_alu_op, dec_is_r;
  logic [1:0] dec_rs;
  logic [3:0] dec_alu;
  logic       take_d;
  logic       valid_e, valid_m;

  always_comb begin
    dec_legal  = 1'b1;
    dec_rw     = 1'b0;
    dec_mw     = 1'b0;
    dec_br     = 1'b0;
    dec_jp     = 1'b0;
    dec_as     = 1'b0;
    dec_asa    = 1'b0;
    dec_rs     = 2'b00;
    dec_alu_op = 1'b0;
    dec_is_r   = 1'b0;
    imm_src_d  = 3'b000;
    dec_alu    = ALU_ADD;
    case (op_d)
      OP_LOAD:   begin dec_rw = 1'b1; dec_as = 1'b1; dec_rs = 2'b01; end
      OP_STORE:  begin dec_mw = 1'b1; dec_as = 1'b1; imm_src_d = 3'b001; end
      OP_R:      begin dec_rw = 1'b1; dec_alu_op = 1'b1; dec_is_r = 1'b1; end
      OP_I:      begin dec_rw = 1'b1; dec_as = 1'b1; dec_alu_op = 1'b1; end
      OP_BRANCH: begin dec_br = 1'b1; dec_alu = ALU_SUB; imm_src_d = 3'b010; end
      OP_JAL:    begin dec_rw = 1'b1; dec_jp = 1'b1; dec_rs = 2'b10; imm_src_d = 3'b011; end
      OP_JALR:   begin dec_rw = 1'b1; dec_jp = 1'b1; dec_as = 1'b1; dec_rs = 2'b10; end
      OP_LUI:    begin dec_rw = 1'b1; dec_rs = 2'b11; imm_src_d = 3'b100; end
      OP_AUIPC:  begin dec_rw = 1'b1; dec_as = 1'b1; dec_asa = 1'b1; imm_src_d = 3'b100; end
      default:   dec_legal = 1'b0;
    endcase
    if (dec_alu_op) begin
      case (funct3_d)
        3'b000:  dec_alu = (dec_is_r && funct7b5_d) ? ALU_SUB : ALU_ADD;
        3'b001:  dec_alu = ALU_SLL;
        3'b010:  dec_alu = ALU_SLT;
        3'b011:  dec_alu = ALU_SLTU;
        3'b100:  dec_alu = ALU_XOR;
        3'b101:  dec_alu = funct7b5_d ? ALU_SRA : ALU_SRL;
        3'b110:  dec_alu = ALU_OR;
        default: dec_alu = ALU_AND;
      endcase
    end
  end

  // Stage registers advance every cycle with no stall: a stage's bundle is
  // meaningful only when its valid bit is 1; bubbles carry all-zero controls.
  assign take_d = valid_d && !flush_e && dec_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      alu_src_e    <= 1'b0;
      alu_src_a_e  <= 1'b0;
      result_src_e <= 2'b00;
      alu_ctrl_e   <= '0;
      illegal_e    <= 1'b0;
      valid_e      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      valid_m      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      valid_w      <= 1'b0;
    end else begin
      reg_write_e  <= take_d && dec_rw;
      mem_write_e  <= take_d && dec_mw;
      branch_e     <= take_d && dec_br;
      jump_e       <= take_d && dec_jp;
      alu_src_e    <= take_d && dec_as;
      alu_src_a_e  <= take_d && dec_asa;
      result_src_e <= take_d ? dec_rs : 2'b00;
      alu_ctrl_e   <= take_d ? ALUCTRL_W'(dec_alu) : '0;
      // flush outranks illegal detection
      illegal_e    <= valid_d && !flush_e && !dec_legal;
      valid_e      <= take_d;
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      valid_m      <= valid_e;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      valid_w      <= valid_m;
    end
  end

`ifdef CTRL_PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (valid_w)   retired_cnt <= retired_cnt + 1'b1;
      if (illegal_e) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: a reference decode model feeds EX/MEM/WB
// expected queues; scenario tasks add targeted checks on top.
module tb_ctrl_pipe;

  localparam int AW = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic          clk, rst;
  logic [6:0]    op_d;
  logic [2:0]    funct3_d;
  logic          funct7b5_d, valid_d, flush_e;
  logic [2:0]    imm_src_d;
  logic          reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e, alu_src_a_e;
  logic [1:0]    result_src_e;
  logic [AW-1:0] alu_ctrl_e;
  logic          illegal_e, reg_write_m, mem_write_m;
  logic [1:0]    result_src_m;
  logic          reg_write_w;
  logic [1:0]    result_src_w;
  logic          valid_w;
`ifdef CTRL_PIPE_PERF_CNT_EN
  logic [CW-1:0] retired_cnt, illegal_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // EX: {rw,mw,br,jp,as,asa,rs[1:0],alu[3:0],ill}; MEM: {rw,mw,rs}; WB: {valid,rw,rs}
  logic [12:0] ex_q[$];
  logic [3:0]  m_q[$];
  logic [3:0]  w_q[$];

  ctrl_pipe #(.ALUCTRL_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
    .valid_d(valid_d), .flush_e(flush_e), .imm_src_d(imm_src_d),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
    .jump_e(jump_e), .alu_src_e(alu_src_e), .alu_src_a_e(alu_src_a_e),
    .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e), .illegal_e(illegal_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w), .valid_w(valid_w)
`ifdef CTRL_PIPE_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic m_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'b001;
      OP_BRANCH:        return 3'b010;
      OP_JAL:           return 3'b011;
      OP_LUI, OP_AUIPC: return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] m_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [12:0] m_ex(input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7, input logic v, input logic fl);
    logic rw, mw, br, jp, as_, asa;
    logic [1:0] rs;
    logic [3:0] alu;
    rw = 0; mw = 0; br = 0; jp = 0; as_ = 0; asa = 0; rs = 2'b00; alu = 4'd0;
    if (fl || !v) return 13'd0;
    if (!m_legal(op)) return 13'd1;
    case (op)
      OP_LOAD:   begin rw = 1; as_ = 1; rs = 2'b01; end
      OP_STORE:  begin mw = 1; as_ = 1; end
      OP_R:      begin rw = 1; alu = m_alu(f3, f7, 1'b1); end
      OP_I:      begin rw = 1; as_ = 1; alu = m_alu(f3, f7, 1'b0); end
      OP_BRANCH: begin br = 1; alu = 4'd1; end
      OP_JAL:    begin rw = 1; jp = 1; rs = 2'b10; end
      OP_JALR:   begin rw = 1; jp = 1; as_ = 1; rs = 2'b10; end
      OP_LUI:    begin rw = 1; rs = 2'b11; end
      default:   begin rw = 1; as_ = 1; asa = 1; end
    endcase
    return {rw, mw, br, jp, as_, asa, rs, alu, 1'b0};
  endfunction

  // driver + scoreboard: one ID cycle, then compare stage outputs after the edge
  task automatic drive_cycle(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic v, input logic fl);
    logic [12:0] e, got_ex, want_ex;
    logic [3:0]  got_m, got_w, want_m, want_w;
    op_d = op; funct3_d = f3; funct7b5_d = f7; valid_d = v; flush_e = fl;
    #1;
    n_checks++;
    if (imm_src_d !== m_imm(op)) begin
      n_fail++;
      $display("FAIL imm_src_d op=%b got=%b exp=%b", op, imm_src_d, m_imm(op));
    end
    e = m_ex(op, f3, f7, v, fl);
    ex_q.push_back(e);
    m_q.push_back({e[12], e[11], e[6:5]});
    w_q.push_back({v && !fl && m_legal(op), e[12], e[6:5]});
    @(posedge clk); #1;
    got_ex = {reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e, alu_src_a_e,
              result_src_e, alu_ctrl_e[3:0], illegal_e};
    want_ex = ex_q.pop_front();
    n_checks++;
    if (got_ex !== want_ex) begin
      n_fail++;
      $display("FAIL ex_bundle op=%b f3=%b f7=%b v=%b fl=%b got=%b exp=%b",
               op, f3, f7, v, fl, got_ex, want_ex);
    end
    if (m_q.size() == 2) begin
      got_m  = {reg_write_m, mem_write_m, result_src_m};
      want_m = m_q.pop_front();
      n_checks++;
      if (got_m !== want_m) begin
        n_fail++;
        $display("FAIL mem_bundle got=%b exp=%b", got_m, want_m);
      end
    end
    if (w_q.size() == 3) begin
      got_w  = {valid_w, reg_write_w, result_src_w};
      want_w = w_q.pop_front();
      n_checks++;
      if (got_w !== want_w) begin
        n_fail++;
        $display("FAIL wb_bundle got=%b exp=%b", got_w, want_w);
      end
    end
  endtask

  task automatic bubble();
    drive_cycle(7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // reset with a valid, flushed load on the inputs; reset must win
  task automatic test_reset();
    logic [18:0] all_out;
    rst = 1'b1; op_d = OP_LOAD; funct3_d = 3'd2; funct7b5_d = 1'b0;
    valid_d = 1'b1; flush_e = 1'b1;
    @(posedge clk); #1;
    all_out = {reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e, alu_src_a_e,
               result_src_e, alu_ctrl_e[3:0], illegal_e, reg_write_m, mem_write_m,
               reg_write_w, valid_w, result_src_w[0]};
    n_checks++;
    if (all_out !== 19'd0 || result_src_m !== 2'b00 || result_src_w !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b rsm=%b rsw=%b exp=0", all_out, result_src_m, result_src_w);
    end
`ifdef CTRL_PIPE_PERF_CNT_EN
    n_checks++;
    if (retired_cnt !== '0 || illegal_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_counters retired=%0d illegal=%0d exp=0", retired_cnt, illegal_cnt);
    end
`endif
    rst = 1'b0; valid_d = 1'b0; flush_e = 1'b0;
    ex_q.delete(); m_q.delete(); w_q.delete();
    m_q.push_back(4'd0);
    w_q.push_back(4'd0); w_q.push_back(4'd0);
  endtask

  task automatic test_r_sub();
    drive_cycle(OP_R, 3'b000, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (reg_write_e !== 1'b1 || alu_ctrl_e !== 4'b0001 || result_src_e !== 2'b00) begin
      n_fail++;
      $display("FAIL r_sub_ex rw=%b alu=%b rs=%b exp rw=1 alu=0001 rs=00",
               reg_write_e, alu_ctrl_e, result_src_e);
    end
    bubble();
    bubble();
    n_checks++;
    if (reg_write_w !== 1'b1 || valid_w !== 1'b1) begin
      n_fail++;
      $display("FAIL r_sub_wb rw_w=%b valid_w=%b exp 1 1", reg_write_w, valid_w);
    end
  endtask

  task automatic test_lui();
    drive_cycle(OP_LUI, 3'b000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (result_src_e !== 2'b11 || reg_write_e !== 1'b1 || alu_src_a_e !== 1'b0) begin
      n_fail++;
      $display("FAIL lui_ex rs=%b rw=%b asa=%b exp 11 1 0", result_src_e, reg_write_e, alu_src_a_e);
    end
  endtask

  task automatic test_flush_store();
    drive_cycle(OP_STORE, 3'b010, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (mem_write_e !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_store_e mem_write_e=%b exp 0", mem_write_e);
    end
    bubble();
    n_checks++;
    if (mem_write_m !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_store_m mem_write_m=%b exp 0", mem_write_m);
    end
    bubble();
    n_checks++;
    if (valid_w !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_store_w valid_w=%b exp 0", valid_w);
    end
  endtask

  task automatic test_illegal();
    drive_cycle(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (illegal_e !== 1'b1 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0 ||
        branch_e !== 1'b0 || jump_e !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_ex ill=%b rw=%b mw=%b br=%b jp=%b exp 1 0 0 0 0",
               illegal_e, reg_write_e, mem_write_e, branch_e, jump_e);
    end
    drive_cycle(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (illegal_e !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_flush ill=%b exp 0", illegal_e);
    end
  endtask

  task automatic test_back_to_back_reset();
    for (int i = 0; i < 3; i++) drive_cycle(OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b0);
    test_reset();
    for (int i = 0; i < 3; i++) begin
      bubble();
      n_checks++;
      if (valid_w !== 1'b0 || reg_write_w !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_wb cyc=%0d valid_w=%b rw_w=%b exp 0 0", i, valid_w, reg_write_w);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[10];
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BAD};
    for (int i = 0; i < 200; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
      drive_cycle(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0));
    end
  endtask

`ifdef CTRL_PIPE_PERF_CNT_EN
  task automatic test_perf();
    test_reset();
    for (int i = 0; i < 17; i++) drive_cycle(OP_I, 3'b000, 1'b0, 1'b1, 1'b0);
    bubble();
    bubble();
    n_checks++;
    if (retired_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL retired_wrap16 got=%0d exp=0", retired_cnt);
    end
    bubble();
    n_checks++;
    if (retired_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL retired_wrap17 got=%0d exp=1", retired_cnt);
    end
    drive_cycle(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b0);
    drive_cycle(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b0);
    bubble();
    n_checks++;
    if (illegal_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL illegal_cnt got=%0d exp=2", illegal_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; op_d = 7'd0; funct3_d = 3'd0; funct7b5_d = 1'b0;
    valid_d = 1'b0; flush_e = 1'b0;
    #2;
    test_reset();
    test_r_sub();
    test_lui();
    test_flush_store();
    test_illegal();
    test_back_to_back_reset();
    test_random();
`ifdef CTRL_PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
